// File: rtl/morphle_cfg_loader.sv
`timescale 1ns/1ps
// morphle_cfg_loader
//   Wishbone-driven configuration loader for the Morphle Logic yblock.
//   Firmware pushes column words into a small FIFO through a 16-byte
//   register window. Each word is driven onto cfg_cbit_o and strobed into
//   the yblock with a timed confclk pulse. The pulse has T_SETUP cycles of
//   setup, T_PULSE cycles high and T_HOLD cycles of hold.
//
//   Ports
//     wb_clk_i, wb_rst_ni    clock, async active-low reset
//     wbs_*                  Wishbone slave (stb/cyc/we/sel/adr/dat in, ack/dat out)
//     cfg_reset_o            yblock reset level (CTRL.b0), 1 out of reset
//     cfg_confclk_o          yblock confclk strobe
//     cfg_cbit_o             yblock cbitin column word
//     cfg_cbit_i             yblock cbitout, captured only with readback
//
//   Register map (adr[3:2])
//     0 CTRL    W: b0 reset level, b1 ABORT, b2 CLR_FLAGS   R: b0
//     1 STATUS  R: b0 busy, b1 done, b2 overflow, b3 full, b4 empty, b15:8 count
//     2 DATA    W: push dat[BW-1:0] when sel[1:0]==2'b11
//     3 RDBK    R: last captured cbitout (0 unless CFG_READBACK_EN)
//
//   Build option: define CFG_READBACK_EN to capture cfg_cbit_i on every
//   confclk falling edge into RDBK.
module morphle_cfg_loader #(
  parameter int          BLOCKWIDTH = 16,
  parameter int          CHAIN_LEN  = 48,
  parameter int          FIFO_DEPTH = 4,
  parameter int          T_SETUP    = 2,
  parameter int          T_PULSE    = 2,
  parameter int          T_HOLD     = 2,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  cfg_reset_o,
  output logic                  cfg_confclk_o,
  output logic [BLOCKWIDTH-1:0] cfg_cbit_o,
  input  logic [BLOCKWIDTH-1:0] cfg_cbit_i
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    CHAIN_L = 8'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, HOLD} state_t;

  state_t                state;
  logic [7:0]            tmr;
  logic [7:0]            count;
  logic                  done, ovf;

  // ---------------------------------------------------------------- bus decode
  logic       hit, acc, wr;
  logic [1:0] ridx;
  logic       wr_ctrl, abort, clr, push_req;

  assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  // One action per transaction: the cycle the ack is being raised.
  assign acc      = hit & ~wbs_ack_o;
  assign wr       = acc & wbs_we_i;
  assign ridx     = wbs_adr_i[3:2];
  assign wr_ctrl  = wr & (ridx == 2'd0);
  assign abort    = wr_ctrl & wbs_dat_i[1];
  assign clr      = wr_ctrl & wbs_dat_i[2];
  assign push_req = wr & (ridx == 2'd2) & (wbs_sel_i[1:0] == 2'b11);

  // ---------------------------------------------------------------- FIFO
  logic [BLOCKWIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wp, rp, occ;
  logic                  fifo_empty, fifo_full;
  logic                  tlast, pop, push, ovf_set;

  assign occ        = wp - rp;
  assign fifo_empty = (occ == '0);
  assign fifo_full  = (occ == DEPTH_L);

  always_comb begin
    tlast = 1'b0;
    case (state)
      SETUP:   tlast = (tmr == 8'(T_SETUP - 1));
      HIGH:    tlast = (tmr == 8'(T_PULSE - 1));
      HOLD:    tlast = (tmr == 8'(T_HOLD - 1));
      default: tlast = 1'b0;
    endcase
  end

  // New words are only taken while the yblock is released; a sequence
  // already running finishes regardless of the reset level.
  assign pop     = ~abort & ~fifo_empty & ~cfg_reset_o &
                   ((state == IDLE) | ((state == HOLD) & tlast));
  // A full FIFO still takes a word if a slot frees up in the same cycle.
  assign push    = push_req & (~fifo_full | pop);
  assign ovf_set = push_req & fifo_full & ~pop;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else if (abort) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wp[AW-1:0]] <= wbs_dat_i[BLOCKWIDTH-1:0];
  end

  // ---------------------------------------------------------------- player FSM
  logic [7:0] cnt_nx;
  assign cnt_nx = count + 8'd1;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= IDLE;
      tmr           <= '0;
      count         <= '0;
      done          <= 1'b0;
      ovf           <= 1'b0;
      cfg_confclk_o <= 1'b0;
      cfg_cbit_o    <= '0;
    end else begin
      if (clr)     ovf <= 1'b0;
      if (ovf_set) ovf <= 1'b1;
      if (clr)     done <= 1'b0;
      if (abort) begin
        state         <= IDLE;
        tmr           <= '0;
        count         <= '0;
        cfg_confclk_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            tmr <= '0;
            if (pop) begin
              cfg_cbit_o <= mem[rp[AW-1:0]];
              state      <= SETUP;
            end
          end
          SETUP: begin
            if (tlast) begin
              tmr           <= '0;
              state         <= HIGH;
              cfg_confclk_o <= 1'b1;
            end else tmr <= tmr + 8'd1;
          end
          HIGH: begin
            if (tlast) begin
              tmr           <= '0;
              state         <= HOLD;
              cfg_confclk_o <= 1'b0;
            end else tmr <= tmr + 8'd1;
          end
          HOLD: begin
            if (tlast) begin
              tmr <= '0;
              // A completed chain sets done even if CLR_FLAGS lands now.
              if (cnt_nx == CHAIN_L) begin
                count <= '0;
                done  <= 1'b1;
              end else count <= cnt_nx;
              if (pop) begin
                cfg_cbit_o <= mem[rp[AW-1:0]];
                state      <= SETUP;
              end else state <= IDLE;
            end else tmr <= tmr + 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------- readback
  logic [31:0] rdbk_val;
`ifdef CFG_READBACK_EN
  logic [BLOCKWIDTH-1:0] rdbk;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                       rdbk <= '0;
    else if (abort)                       rdbk <= '0;
    else if ((state == HIGH) && tlast)    rdbk <= cfg_cbit_i;
  end
  assign rdbk_val = 32'(rdbk);
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i};
`else
  assign rdbk_val = '0;
  logic unused_bits;
  assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:2], wbs_dat_i, cfg_cbit_i};
`endif

  // ---------------------------------------------------------------- registers / response
  logic [31:0] status, rd_val;
  assign status = {16'b0, count, 3'b0, fifo_empty, fifo_full, ovf, done, (state != IDLE)};

  always_comb begin
    rd_val = '0;
    case (ridx)
      2'd0:    rd_val = {31'b0, cfg_reset_o};
      2'd1:    rd_val = status;
      2'd3:    rd_val = rdbk_val;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      cfg_reset_o <= 1'b1;
    end else begin
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rd_val : 32'h0;
      if (wr_ctrl) cfg_reset_o <= wbs_dat_i[0];
    end
  end

endmodule

// File: tb/tb_morphle_cfg_loader.sv
`timescale 1ns/1ps
// Randomized bench for morphle_cfg_loader. A timing model predicts, for
// every accepted word, the absolute time of its confclk rising edge:
//   pop = max(push_edge + 1 cycle, previous_pop + 6 cycles), rise = pop + 2 cycles.
// Occupancy at a push is the number of accepted words not yet popped.
module tb_morphle_cfg_loader;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0, A_STAT = BASE + 32'h4,
                          A_DATA = BASE + 32'h8, A_RDBK = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        ack;
  logic [31:0] rdat;
  logic        creset, confclk;
  logic [15:0] cbit_out, cbit_in;

  always #5 clk = ~clk;

  morphle_cfg_loader dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cfg_reset_o(creset), .cfg_confclk_o(confclk),
    .cfg_cbit_o(cbit_out), .cfg_cbit_i(cbit_in)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ------------------------------------------------------------ model
  typedef struct { longint rise; logic [15:0] word; } exp_t;
  exp_t   expq[$];
  bit     mon_en = 1'b0;
  int     pulse_n = 0;
  longint last_rise = 0;
  longint last_pop = -1000;
  bit     m_ovf = 1'b0;
  int     m_total = 0;

  task automatic model_push(input longint tp, input logic [15:0] w);
    int occ;
    longint p;
    occ = 0;
    foreach (expq[i]) if (expq[i].rise - 20 > tp) occ++;
    if (occ >= 4) m_ovf = 1'b1;
    else begin
      p = (tp + 10 > last_pop + 60) ? tp + 10 : last_pop + 60;
      last_pop = p;
      expq.push_back('{p + 20, w});
      m_total++;
    end
  endtask

  always @(posedge confclk) begin
    exp_t e;
    pulse_n++;
    last_rise = $time;
    if (mon_en) begin
      if (expq.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        chk("rise_time", 32'($time), 32'(e.rise));
        chk("cbit_at_rise", {16'h0, cbit_out}, {16'h0, e.word});
      end
    end
  end

  always @(negedge confclk)
    if (mon_en && rst_n) chk("high_width", 32'($time - last_rise), 32'd20);

  // ------------------------------------------------------------ bus
  task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output longint tp);
    @(negedge clk);
    stb = 1; cyc = 1; we = 1; adr = a; wdat = d; sel = s;
    @(posedge clk);
    tp = longint'($time);
    #1 chk("wr_ack", {31'b0, ack}, 32'd1);
    @(negedge clk);
    stb = 0; cyc = 0; we = 0;
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] d, output logic ak);
    @(negedge clk);
    stb = 1; cyc = 1; we = 0; adr = a; sel = 4'hF;
    @(posedge clk);
    #1 d = rdat; ak = ack;
    @(negedge clk);
    stb = 0; cyc = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 1500 && expq.size() != 0; k++) @(negedge clk);
    chk("drain", 32'(expq.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_high();
    for (int k = 0; k < 40 && confclk !== 1'b1; k++) begin
      @(posedge clk); #1;
    end
    chk("saw_high", {31'b0, confclk}, 32'd1);
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(m_total % 48) << 8) | 32'h10 | (m_ovf ? 32'h4 : 32'h0) |
           (m_total >= 48 ? 32'h2 : 32'h0);
  endfunction

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [31:0] d;
    logic        ak;
    longint      tp;
    int          pn;
    logic [15:0] fw [5];

    rst_n = 0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    cbit_in = 16'h1234;

    // reset state
    @(posedge clk); #1;
    chk("rst_creset", {31'b0, creset}, 32'd1);
    chk("rst_confclk", {31'b0, confclk}, 32'd0);
    chk("rst_cbit", {16'h0, cbit_out}, 32'd0);
    chk("rst_ack", {31'b0, ack}, 32'd0);
    @(negedge clk); rst_n = 1;
    wb_read(A_STAT, d, ak);
    chk("rst_status", d, 32'h10);
    wb_read(BASE + 32'h10, d, ak);
    chk("no_ack_outside", {31'b0, ak}, 32'd0);

    // single word
    mon_en = 1;
    wb_write(A_CTRL, 32'h0, 4'hF, tp);
    wb_read(A_CTRL, d, ak);
    chk("ctrl_read", d, 32'h0);
    wb_write(A_DATA, 32'h0000_A5A5, 4'hF, tp);
    model_push(tp, 16'hA5A5);
    drain();
    chk("cbit_hold", {16'h0, cbit_out}, 32'h0000_A5A5);
    wb_read(A_STAT, d, ak);
    chk("status_one", d, 32'h0110);

    // random stream: gaps, partial selects, overflow, chain wrap
    for (int i = 0; i < 64; i++) begin
      logic [31:0] rw;
      logic [3:0]  rs;
      repeat ($urandom_range(0, 6)) @(negedge clk);
      rw = $urandom;
      rs = ($urandom_range(0, 9) == 0) ? 4'b0001 : 4'b1111;
      wb_write(A_DATA, rw, rs, tp);
      if (rs[1:0] == 2'b11) model_push(tp, rw[15:0]);
    end
    drain();
    wb_read(A_STAT, d, ak);
    chk("status_random", d, exp_status());

    // frozen: fill and overflow, then release
    wb_write(A_CTRL, 32'h7, 4'hF, tp);
    m_total = 0; m_ovf = 0;
    chk("frozen_creset", {31'b0, creset}, 32'd1);
    pn = pulse_n;
    for (int i = 0; i < 5; i++) begin
      fw[i] = 16'($urandom);
      wb_write(A_DATA, {16'h0, fw[i]}, 4'hF, tp);
    end
    repeat (10) @(negedge clk);
    chk("frozen_no_pulse", 32'(pulse_n), 32'(pn));
    wb_read(A_STAT, d, ak);
    chk("frozen_status", d, 32'h000C);
    wb_write(A_CTRL, 32'h0, 4'hF, tp);
    for (int k = 0; k < 4; k++) expq.push_back('{tp + 10 + 60 * k + 20, fw[k]});
    last_pop = tp + 10 + 180;
    drain();
    wb_read(A_STAT, d, ak);
    chk("release_status", d, 32'h0414);

    // abort during HIGH
    mon_en = 0;
    wb_write(A_DATA, 32'h1111, 4'hF, tp);
    wb_write(A_DATA, 32'h2222, 4'hF, tp);
    wait_high();
    pn = pulse_n;
    wb_write(A_CTRL, 32'h2, 4'hF, tp);
    chk("abort_confclk", {31'b0, confclk}, 32'd0);
    repeat (20) @(negedge clk);
    chk("abort_no_pulse", 32'(pulse_n), 32'(pn));
    wb_read(A_STAT, d, ak);
    chk("abort_status", d, 32'h0014);

    // async reset mid-HIGH
    wb_write(A_DATA, 32'h3333, 4'hF, tp);
    wait_high();
    #2 rst_n = 0;
    #1;
    chk("arst_confclk", {31'b0, confclk}, 32'd0);
    chk("arst_creset", {31'b0, creset}, 32'd1);
    chk("arst_cbit", {16'h0, cbit_out}, 32'd0);
    @(negedge clk); rst_n = 1;
    wb_read(A_STAT, d, ak);
    chk("arst_status", d, 32'h10);
    wb_read(A_RDBK, d, ak);
    chk("rdbk_after_rst", d, 32'h0);

    // readback
    expq.delete(); last_pop = -1000; m_total = 0; m_ovf = 0;
    mon_en = 1;
    wb_write(A_CTRL, 32'h0, 4'hF, tp);
    wb_write(A_DATA, 32'h00FF, 4'hF, tp);
    model_push(tp, 16'h00FF);
    drain();
    wb_read(A_RDBK, d, ak);
`ifdef CFG_READBACK_EN
    chk("rdbk", d, 32'h0000_1234);
`else
    chk("rdbk", d, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
